// File: rtl/force_output_collector.sv
// force_output_collector
// Collects reference- and neighbor-particle force records for one home cell
// into two independent FIFOs and merges them onto a single valid/ready
// record stream using round-robin arbitration.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   start                          begin a new home-cell collection (flushes)
//   ref_*  / ref_forceoutput_valid reference-particle record input (no backpressure)
//   neighbor_* / neighbor_forceoutput_valid  neighbor-particle record input
//   in_home_cell_evaluation_done   level: evaluation of the home cell finished
//   out_particle_id, out_Force_*,
//   out_is_neighbor, out_valid,
//   out_ready                      merged record stream
//   out_collect_done               high in DONE until the next start
//   out_overflow                   sticky: a record was dropped on a full FIFO
//   out_ref_count, out_neighbor_count  saturating accepted-record counters
module force_output_collector #(
  parameter int unsigned DATA_WIDTH        = 32,
  parameter int unsigned PARTICLE_ID_WIDTH = 20,
  parameter int unsigned FIFO_DEPTH        = 16,
  parameter int unsigned FIFO_ADDR_WIDTH   = 4,
  parameter int unsigned COUNT_WIDTH       = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [PARTICLE_ID_WIDTH-1:0] ref_particle_id,
  input  logic [DATA_WIDTH-1:0]        ref_LJ_Force_X,
  input  logic [DATA_WIDTH-1:0]        ref_LJ_Force_Y,
  input  logic [DATA_WIDTH-1:0]        ref_LJ_Force_Z,
  input  logic                         ref_forceoutput_valid,
  input  logic [PARTICLE_ID_WIDTH-1:0] neighbor_particle_id,
  input  logic [DATA_WIDTH-1:0]        neighbor_LJ_Force_X,
  input  logic [DATA_WIDTH-1:0]        neighbor_LJ_Force_Y,
  input  logic [DATA_WIDTH-1:0]        neighbor_LJ_Force_Z,
  input  logic                         neighbor_forceoutput_valid,
  input  logic                         in_home_cell_evaluation_done,
  output logic [PARTICLE_ID_WIDTH-1:0] out_particle_id,
  output logic [DATA_WIDTH-1:0]        out_Force_X,
  output logic [DATA_WIDTH-1:0]        out_Force_Y,
  output logic [DATA_WIDTH-1:0]        out_Force_Z,
  output logic                         out_is_neighbor,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         out_collect_done,
  output logic                         out_overflow,
  output logic [COUNT_WIDTH-1:0]       out_ref_count,
  output logic [COUNT_WIDTH-1:0]       out_neighbor_count
);

  localparam int unsigned REC_W = PARTICLE_ID_WIDTH + 3 * DATA_WIDTH;
  localparam int unsigned CNT_W = FIFO_ADDR_WIDTH + 1;

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DRAIN, S_DONE} state_t;

  state_t state, state_next;
  logic   accept, done_next;

  logic [REC_W-1:0]           ref_mem [FIFO_DEPTH];
  logic [REC_W-1:0]           nbr_mem [FIFO_DEPTH];
  logic [FIFO_ADDR_WIDTH-1:0] ref_wr_ptr, ref_rd_ptr, nbr_wr_ptr, nbr_rd_ptr;
  logic [CNT_W-1:0]           ref_cnt, nbr_cnt;

  logic ref_empty, nbr_empty, ref_full, nbr_full;
  logic ref_wr, nbr_wr, ref_drop, nbr_drop;
  logic load, pick_nbr, ref_rd, nbr_rd, prefer_nbr;
  logic [REC_W-1:0] rd_rec;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Next-state logic; start overrides every state
  always_comb begin
    state_next = state;
    if (start) begin
      state_next = S_COLLECT;
    end else begin
      case (state)
        S_COLLECT: if (in_home_cell_evaluation_done) state_next = S_DRAIN;
        S_DRAIN:   if (ref_empty && nbr_empty && !out_valid &&
                       !ref_forceoutput_valid && !neighbor_forceoutput_valid)
                     state_next = S_DONE;
        default:   state_next = state;
      endcase
    end
  end

  // FSM outputs: write enable window and next value of the done flag
  always_comb begin
    accept    = 1'b0;
    done_next = 1'b0;
    if (!start && (state == S_COLLECT || state == S_DRAIN)) accept = 1'b1;
    if (state_next == S_DONE) done_next = 1'b1;
  end

  assign ref_empty = (ref_cnt == '0);
  assign nbr_empty = (nbr_cnt == '0);
  assign ref_full  = (ref_cnt == CNT_W'(FIFO_DEPTH));
  assign nbr_full  = (nbr_cnt == CNT_W'(FIFO_DEPTH));

  // Fullness is judged before this edge's pop, so a same-cycle read never rescues a write
  assign ref_wr   = accept && ref_forceoutput_valid && !ref_full;
  assign nbr_wr   = accept && neighbor_forceoutput_valid && !nbr_full;
  assign ref_drop = accept && ref_forceoutput_valid && ref_full;
  assign nbr_drop = accept && neighbor_forceoutput_valid && nbr_full;

  // Round-robin: a lone non-empty FIFO wins, otherwise the pointer decides
  assign load     = (!out_valid || out_ready) && (!ref_empty || !nbr_empty);
  assign pick_nbr = !nbr_empty && (ref_empty || prefer_nbr);
  assign ref_rd   = load && !pick_nbr;
  assign nbr_rd   = load && pick_nbr;
  assign rd_rec   = pick_nbr ? nbr_mem[nbr_rd_ptr] : ref_mem[ref_rd_ptr];

  // FIFO storage
  always_ff @(posedge clk) begin
    if (ref_wr) ref_mem[ref_wr_ptr] <= {ref_particle_id, ref_LJ_Force_X,
                                        ref_LJ_Force_Y, ref_LJ_Force_Z};
    if (nbr_wr) nbr_mem[nbr_wr_ptr] <= {neighbor_particle_id, neighbor_LJ_Force_X,
                                        neighbor_LJ_Force_Y, neighbor_LJ_Force_Z};
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst || start) begin
      ref_wr_ptr <= '0;
      ref_rd_ptr <= '0;
      ref_cnt    <= '0;
      nbr_wr_ptr <= '0;
      nbr_rd_ptr <= '0;
      nbr_cnt    <= '0;
    end else begin
      if (ref_wr) ref_wr_ptr <= ref_wr_ptr + FIFO_ADDR_WIDTH'(1);
      if (ref_rd) ref_rd_ptr <= ref_rd_ptr + FIFO_ADDR_WIDTH'(1);
      if (nbr_wr) nbr_wr_ptr <= nbr_wr_ptr + FIFO_ADDR_WIDTH'(1);
      if (nbr_rd) nbr_rd_ptr <= nbr_rd_ptr + FIFO_ADDR_WIDTH'(1);
      ref_cnt <= ref_cnt + CNT_W'(ref_wr) - CNT_W'(ref_rd);
      nbr_cnt <= nbr_cnt + CNT_W'(nbr_wr) - CNT_W'(nbr_rd);
    end
  end

  // Output register and arbiter pointer
  always_ff @(posedge clk) begin
    if (rst || start) begin
      out_valid       <= 1'b0;
      out_is_neighbor <= 1'b0;
      out_particle_id <= '0;
      out_Force_X     <= '0;
      out_Force_Y     <= '0;
      out_Force_Z     <= '0;
      prefer_nbr      <= 1'b0;
    end else if (load) begin
      out_valid       <= 1'b1;
      out_is_neighbor <= pick_nbr;
      out_particle_id <= rd_rec[REC_W-1 -: PARTICLE_ID_WIDTH];
      out_Force_X     <= rd_rec[3*DATA_WIDTH-1 -: DATA_WIDTH];
      out_Force_Y     <= rd_rec[2*DATA_WIDTH-1 -: DATA_WIDTH];
      out_Force_Z     <= rd_rec[DATA_WIDTH-1:0];
      prefer_nbr      <= !pick_nbr;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Status: saturating counters, sticky overflow, done flag
  always_ff @(posedge clk) begin
    if (rst || start) begin
      out_ref_count      <= '0;
      out_neighbor_count <= '0;
      out_overflow       <= 1'b0;
    end else begin
      if (ref_wr && out_ref_count != '1)
        out_ref_count <= out_ref_count + COUNT_WIDTH'(1);
      if (nbr_wr && out_neighbor_count != '1)
        out_neighbor_count <= out_neighbor_count + COUNT_WIDTH'(1);
      if (ref_drop || nbr_drop) out_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) out_collect_done <= 1'b0;
    else     out_collect_done <= done_next;
  end

endmodule

// File: tb/tb_force_output_collector.sv
// Testbench for force_output_collector: directed scenarios plus a randomized
// run, all checked against a queue-based transaction model of the collector.
module tb_force_output_collector;

  localparam int DW = 32;
  localparam int IW = 20;
  localparam int CW = 16;
  localparam int DEPTH = 16;
  localparam int M_IDLE = 0, M_COLLECT = 1, M_DRAIN = 2, M_DONE = 3;

  typedef struct packed {
    logic [IW-1:0] id;
    logic [DW-1:0] x;
    logic [DW-1:0] y;
    logic [DW-1:0] z;
  } rec_t;

  logic          clk = 1'b0;
  logic          rst, start;
  logic [IW-1:0] ref_particle_id, neighbor_particle_id;
  logic [DW-1:0] ref_LJ_Force_X, ref_LJ_Force_Y, ref_LJ_Force_Z;
  logic [DW-1:0] neighbor_LJ_Force_X, neighbor_LJ_Force_Y, neighbor_LJ_Force_Z;
  logic          ref_forceoutput_valid, neighbor_forceoutput_valid;
  logic          in_home_cell_evaluation_done;
  logic [IW-1:0] out_particle_id;
  logic [DW-1:0] out_Force_X, out_Force_Y, out_Force_Z;
  logic          out_is_neighbor, out_valid, out_ready;
  logic          out_collect_done, out_overflow;
  logic [CW-1:0] out_ref_count, out_neighbor_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  force_output_collector dut (
    .clk(clk), .rst(rst), .start(start),
    .ref_particle_id(ref_particle_id), .ref_LJ_Force_X(ref_LJ_Force_X),
    .ref_LJ_Force_Y(ref_LJ_Force_Y), .ref_LJ_Force_Z(ref_LJ_Force_Z),
    .ref_forceoutput_valid(ref_forceoutput_valid),
    .neighbor_particle_id(neighbor_particle_id), .neighbor_LJ_Force_X(neighbor_LJ_Force_X),
    .neighbor_LJ_Force_Y(neighbor_LJ_Force_Y), .neighbor_LJ_Force_Z(neighbor_LJ_Force_Z),
    .neighbor_forceoutput_valid(neighbor_forceoutput_valid),
    .in_home_cell_evaluation_done(in_home_cell_evaluation_done),
    .out_particle_id(out_particle_id), .out_Force_X(out_Force_X),
    .out_Force_Y(out_Force_Y), .out_Force_Z(out_Force_Z),
    .out_is_neighbor(out_is_neighbor), .out_valid(out_valid), .out_ready(out_ready),
    .out_collect_done(out_collect_done), .out_overflow(out_overflow),
    .out_ref_count(out_ref_count), .out_neighbor_count(out_neighbor_count)
  );

  // Transaction model: per-source queues, one held output record, RR pointer
  rec_t    mq_ref[$], mq_nbr[$];
  rec_t    m_out, in_r, in_n;
  bit      m_ov, m_isn, m_prefer_nbr, m_ovf, m_consumed, m_take_n, m_room_r, m_room_n, m_accept;
  logic [CW-1:0] m_rcnt, m_ncnt;
  int      m_state, m_ns;

  always @(posedge clk) begin
    in_r = {ref_particle_id, ref_LJ_Force_X, ref_LJ_Force_Y, ref_LJ_Force_Z};
    in_n = {neighbor_particle_id, neighbor_LJ_Force_X, neighbor_LJ_Force_Y, neighbor_LJ_Force_Z};
    if (rst || start) begin
      mq_ref.delete(); mq_nbr.delete();
      m_ov = 0; m_isn = 0; m_prefer_nbr = 0; m_ovf = 0; m_rcnt = '0; m_ncnt = '0;
      m_out = '0;
      m_state = rst ? M_IDLE : M_COLLECT;
    end else begin
      m_ns = m_state;
      if (m_state == M_COLLECT && in_home_cell_evaluation_done) m_ns = M_DRAIN;
      if (m_state == M_DRAIN && mq_ref.size() == 0 && mq_nbr.size() == 0 && !m_ov &&
          !ref_forceoutput_valid && !neighbor_forceoutput_valid) m_ns = M_DONE;
      m_accept   = (m_state == M_COLLECT) || (m_state == M_DRAIN);
      m_room_r   = mq_ref.size() < DEPTH;
      m_room_n   = mq_nbr.size() < DEPTH;
      m_consumed = m_ov && out_ready;
      if ((!m_ov || m_consumed) && (mq_ref.size() > 0 || mq_nbr.size() > 0)) begin
        m_take_n = (mq_nbr.size() > 0) && (mq_ref.size() == 0 || m_prefer_nbr);
        if (m_take_n) m_out = mq_nbr.pop_front();
        else          m_out = mq_ref.pop_front();
        m_isn = m_take_n; m_prefer_nbr = !m_take_n; m_ov = 1;
      end else if (m_consumed) begin
        m_ov = 0;
      end
      if (m_accept && ref_forceoutput_valid) begin
        if (m_room_r) begin mq_ref.push_back(in_r); if (m_rcnt != 16'hFFFF) m_rcnt++; end
        else m_ovf = 1;
      end
      if (m_accept && neighbor_forceoutput_valid) begin
        if (m_room_n) begin mq_nbr.push_back(in_n); if (m_ncnt != 16'hFFFF) m_ncnt++; end
        else m_ovf = 1;
      end
      m_state = m_ns;
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive_ref(input bit v, input logic [IW-1:0] id);
    ref_forceoutput_valid = v; ref_particle_id = id;
    ref_LJ_Force_X = $urandom; ref_LJ_Force_Y = $urandom; ref_LJ_Force_Z = $urandom;
  endtask

  task automatic drive_nbr(input bit v, input logic [IW-1:0] id);
    neighbor_forceoutput_valid = v; neighbor_particle_id = id;
    neighbor_LJ_Force_X = $urandom; neighbor_LJ_Force_Y = $urandom; neighbor_LJ_Force_Z = $urandom;
  endtask

  task automatic do_start();
    start = 1; drive_ref(0, '0); drive_nbr(0, '0);
    tick();
    start = 0;
  endtask

  task automatic test_reset();
    rst = 1; start = 0; out_ready = 0; in_home_cell_evaluation_done = 0;
    drive_ref(0, '0); drive_nbr(0, '0);
    tick(); tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%0b exp=0", out_valid); end
    n_checks++; if (out_collect_done !== 1'b0 || out_overflow !== 1'b0) begin n_fail++;
      $display("FAIL reset_flags done=%0b ovf=%0b exp=0/0", out_collect_done, out_overflow); end
    n_checks++; if (out_ref_count !== 16'd0 || out_neighbor_count !== 16'd0) begin n_fail++;
      $display("FAIL reset_counts got=%0d/%0d exp=0/0", out_ref_count, out_neighbor_count); end
    n_checks++; if ({out_particle_id, out_Force_X, out_Force_Y, out_Force_Z, out_is_neighbor} !== '0) begin n_fail++;
      $display("FAIL reset_payload id=%h x=%h exp=0", out_particle_id, out_Force_X); end
    rst = 0;
  endtask

  task automatic test_single_latency();
    out_ready = 1;
    do_start();
    drive_ref(1, 20'h00123); ref_LJ_Force_X = 32'h3F800000;
    tick();
    drive_ref(0, '0);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL lat_t1_valid got=%0b exp=0", out_valid); end
    tick();
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL lat_t2_valid got=%0b exp=1", out_valid); end
    n_checks++; if (out_particle_id !== 20'h00123 || out_Force_X !== 32'h3F800000 || out_is_neighbor !== 1'b0) begin
      n_fail++; $display("FAIL lat_payload id=%h x=%h isn=%0b exp=00123/3f800000/0", out_particle_id, out_Force_X, out_is_neighbor); end
    n_checks++; if (out_ref_count !== 16'd1) begin n_fail++; $display("FAIL lat_ref_count got=%0d exp=1", out_ref_count); end
    tick();
  endtask

  task automatic test_alternate();
    logic [IW-1:0] got_id [8];
    logic          got_n  [8];
    int ngot = 0;
    logic [IW-1:0] exp_id;
    out_ready = 1;
    do_start();
    for (int c = 0; c < 24; c++) begin
      drive_ref(c < 4, IW'(32'h100 + c));
      drive_nbr(c < 4, IW'(32'h200 + c));
      tick();
      if (out_valid) begin
        if (ngot < 8) begin got_id[ngot] = out_particle_id; got_n[ngot] = out_is_neighbor; end
        ngot++;
      end
    end
    n_checks++; if (ngot != 8) begin n_fail++; $display("FAIL alt_num_records got=%0d exp=8", ngot); end
    for (int k = 0; k < 8 && k < ngot; k++) begin
      exp_id = IW'(((k % 2) ? 32'h200 : 32'h100) + k / 2);
      n_checks++; if (got_id[k] !== exp_id || got_n[k] !== 1'(k % 2)) begin n_fail++;
        $display("FAIL alt_rec%0d id=%h isn=%0b exp=%h/%0d", k, got_id[k], got_n[k], exp_id, k % 2); end
    end
    n_checks++; if (out_ref_count !== 16'd4 || out_neighbor_count !== 16'd4) begin n_fail++;
      $display("FAIL alt_counts got=%0d/%0d exp=4/4", out_ref_count, out_neighbor_count); end
  endtask

  task automatic fill_ref_20(input logic [IW-1:0] base);
    out_ready = 0;
    do_start();
    for (int c = 0; c < 20; c++) begin drive_ref(1, base + IW'(c)); tick(); end
    drive_ref(0, '0);
    tick(); tick();
  endtask

  task automatic test_overflow();
    int ngot = 0;
    fill_ref_20(20'h300);
    n_checks++; if (out_overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag got=%0b exp=1", out_overflow); end
    n_checks++; if (out_ref_count !== 16'd17) begin n_fail++; $display("FAIL ovf_ref_count got=%0d exp=17", out_ref_count); end
    n_checks++; if (out_valid !== 1'b1 || out_particle_id !== 20'h300) begin n_fail++;
      $display("FAIL ovf_held valid=%0b id=%h exp=1/00300", out_valid, out_particle_id); end
    out_ready = 1;
    for (int c = 0; c < 30; c++) begin
      if (out_valid) begin
        n_checks++; if (out_particle_id !== 20'h300 + IW'(ngot)) begin n_fail++;
          $display("FAIL ovf_order%0d got=%h exp=%h", ngot, out_particle_id, 20'h300 + IW'(ngot)); end
        ngot++;
      end
      tick();
    end
    n_checks++; if (ngot != 17) begin n_fail++; $display("FAIL ovf_drained got=%0d exp=17", ngot); end
  endtask

  task automatic test_done();
    int xfers = 0;
    do_start();
    in_home_cell_evaluation_done = 1;
    for (int c = 0; c < 60 && xfers < 5; c++) begin
      drive_ref(c < 5, IW'(32'h400 + c));
      out_ready = c[0];
      n_checks++; if (out_collect_done !== 1'b0) begin n_fail++;
        $display("FAIL done_early cycle=%0d got=%0b exp=0 xfers=%0d", c, out_collect_done, xfers); end
      if (out_valid && out_ready) xfers++;
      tick();
    end
    drive_ref(0, '0);
    n_checks++; if (xfers != 5) begin n_fail++; $display("FAIL done_xfers got=%0d exp=5 (timeout)", xfers); end
    n_checks++; if (out_collect_done !== 1'b0) begin n_fail++; $display("FAIL done_after_last got=%0b exp=0", out_collect_done); end
    tick();
    for (int c = 0; c < 4; c++) begin
      n_checks++; if (out_collect_done !== 1'b1) begin n_fail++; $display("FAIL done_hold%0d got=%0b exp=1", c, out_collect_done); end
      tick();
    end
    n_checks++; if (out_ref_count !== 16'd5) begin n_fail++; $display("FAIL done_ref_count got=%0d exp=5", out_ref_count); end
    in_home_cell_evaluation_done = 0;
  endtask

  task automatic test_reset_mid_drain();
    out_ready = 0;
    do_start();
    in_home_cell_evaluation_done = 1;
    for (int c = 0; c < 3; c++) begin drive_ref(1, IW'(32'h500 + c)); drive_nbr(1, IW'(32'h600 + c)); tick(); end
    drive_ref(0, '0); drive_nbr(0, '0);
    tick();
    n_checks++; if (out_valid !== 1'b1 || out_ref_count !== 16'd3) begin n_fail++;
      $display("FAIL rstmid_pre valid=%0b refcnt=%0d exp=1/3", out_valid, out_ref_count); end
    rst = 1;
    tick();
    rst = 0;
    n_checks++; if (out_valid !== 1'b0 || out_collect_done !== 1'b0 || out_particle_id !== '0) begin n_fail++;
      $display("FAIL rstmid_out valid=%0b done=%0b id=%h exp=0/0/0", out_valid, out_collect_done, out_particle_id); end
    n_checks++; if (out_ref_count !== 16'd0 || out_neighbor_count !== 16'd0) begin n_fail++;
      $display("FAIL rstmid_counts got=%0d/%0d exp=0/0", out_ref_count, out_neighbor_count); end
    out_ready = 1;
    for (int c = 0; c < 3; c++) begin drive_ref(1, IW'(c)); drive_nbr(1, IW'(c)); tick(); end
    drive_ref(0, '0); drive_nbr(0, '0);
    tick(); tick();
    n_checks++; if (out_valid !== 1'b0 || out_ref_count !== 16'd0 || out_neighbor_count !== 16'd0) begin n_fail++;
      $display("FAIL idle_ignore valid=%0b cnt=%0d/%0d exp=0/0/0", out_valid, out_ref_count, out_neighbor_count); end
    rst = 1; start = 1;
    tick();
    rst = 0; start = 0;
    drive_ref(1, 20'h777); tick(); tick();
    drive_ref(0, '0); tick();
    n_checks++; if (out_ref_count !== 16'd0 || out_valid !== 1'b0) begin n_fail++;
      $display("FAIL rst_over_start refcnt=%0d valid=%0b exp=0/0", out_ref_count, out_valid); end
    in_home_cell_evaluation_done = 0;
  endtask

  task automatic test_restart_from_done();
    int c = 0;
    fill_ref_20(20'h800);
    in_home_cell_evaluation_done = 1; out_ready = 1;
    while (out_collect_done !== 1'b1 && c < 60) begin tick(); c++; end
    n_checks++; if (out_collect_done !== 1'b1) begin n_fail++; $display("FAIL restart_reach_done got=%0b exp=1 (timeout)", out_collect_done); end
    n_checks++; if (out_overflow !== 1'b1) begin n_fail++; $display("FAIL restart_stale_ovf got=%0b exp=1", out_overflow); end
    in_home_cell_evaluation_done = 0;
    do_start();
    n_checks++; if (out_overflow !== 1'b0 || out_collect_done !== 1'b0) begin n_fail++;
      $display("FAIL restart_flags ovf=%0b done=%0b exp=0/0", out_overflow, out_collect_done); end
    n_checks++; if (out_ref_count !== 16'd0 || out_neighbor_count !== 16'd0 || out_valid !== 1'b0) begin n_fail++;
      $display("FAIL restart_clear cnt=%0d/%0d valid=%0b exp=0/0/0", out_ref_count, out_neighbor_count, out_valid); end
  endtask

  task automatic test_random();
    do_start();
    for (int c = 0; c < 420; c++) begin
      start = (c > 0 && c < 300 && $urandom_range(0, 149) == 0);
      drive_ref(c < 340 && $urandom_range(0, 9) < 6, IW'($urandom));
      drive_nbr(c < 340 && $urandom_range(0, 9) < 5, IW'($urandom));
      out_ready = ($urandom_range(0, 9) < 7);
      in_home_cell_evaluation_done = (c >= 300);
      tick();
      n_checks++; if (out_valid !== m_ov) begin n_fail++;
        $display("FAIL rand_valid cycle=%0d got=%0b exp=%0b", c, out_valid, m_ov); end
      if (m_ov) begin
        n_checks++; if ({out_particle_id, out_Force_X, out_Force_Y, out_Force_Z} !== m_out || out_is_neighbor !== m_isn) begin
          n_fail++; $display("FAIL rand_payload cycle=%0d id=%h isn=%0b exp=%h/%0b", c, out_particle_id, out_is_neighbor, m_out.id, m_isn); end
      end
      n_checks++; if (out_ref_count !== m_rcnt || out_neighbor_count !== m_ncnt) begin n_fail++;
        $display("FAIL rand_counts cycle=%0d got=%0d/%0d exp=%0d/%0d", c, out_ref_count, out_neighbor_count, m_rcnt, m_ncnt); end
      n_checks++; if (out_overflow !== m_ovf || out_collect_done !== (m_state == M_DONE)) begin n_fail++;
        $display("FAIL rand_flags cycle=%0d ovf=%0b done=%0b exp=%0b/%0b", c, out_overflow, out_collect_done, m_ovf, m_state == M_DONE); end
    end
    start = 0;
    n_checks++; if (out_collect_done !== 1'b1) begin n_fail++; $display("FAIL rand_final_done got=%0b exp=1", out_collect_done); end
    in_home_cell_evaluation_done = 0;
  endtask

  initial begin
    rst = 1; start = 0; out_ready = 0; in_home_cell_evaluation_done = 0;
    drive_ref(0, '0); drive_nbr(0, '0);
    test_reset();
    test_single_latency();
    test_alternate();
    test_overflow();
    test_done();
    test_reset_mid_drain();
    test_restart_from_done();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
